// File: rtl/amostrador_sensores.sv
// -----------------------------------------------------------------------------
// amostrador_sensores
//
// Acquisition stage in front of the averaging/grading stage. One shared 4-bit
// request/valid sensor bus is polled for four channels in turn. Each channel
// gets 2^K_AMOSTRAS readings. Their average is taken by truncating shift. All
// four grades are published together with a one-cycle `pronto` strobe, so the
// downstream stage always sees a set from a single round.
//
// Parameters
//   K_AMOSTRAS  log2 of samples per channel per round (0..4)
//   TIMEOUT     REQ cycles to wait for sensor_valido before using a 0 sample (1..255)
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high
//   enable         in   start/continue sampling (looked at in IDLE and PUBLISH only)
//   sensor_dado    in   [3:0] reading from the selected sensor
//   sensor_valido  in   sensor_dado valid
//   sensor_req     out  read request to the sensor bus
//   sensor_sel     out  [1:0] channel: 0 temperatura, 1 pH, 2 luminosidade, 3 umidade
//   temperatura, pH, luminosidade, umidade  out [3:0] published averaged grades
//   pronto         out  one-cycle strobe when a new set is published
//   erro           out  at least one sample of the published round timed out
//   ocupado        out  high in every state except IDLE
//   estado_dbg     out  [1:0] current FSM state (0 IDLE, 1 REQ, 2 GAP, 3 PUBLISH)
//
// Sensor bus handshake: a transfer happens on a rising edge where sensor_req
// and sensor_valido are both 1. sensor_valido is ignored while sensor_req is 0.
// sensor_req drops for one GAP cycle after every transfer or timeout, so each
// request starts with a fresh rising edge.
// -----------------------------------------------------------------------------
module amostrador_sensores #(
    parameter int K_AMOSTRAS = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] sensor_dado,
    input  logic       sensor_valido,
    output logic       sensor_req,
    output logic [1:0] sensor_sel,
    output logic [3:0] temperatura,
    output logic [3:0] pH,
    output logic [3:0] luminosidade,
    output logic [3:0] umidade,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado,
    output logic [1:0] estado_dbg
);

    localparam int         ACC_W      = 4 + K_AMOSTRAS;
    localparam logic [4:0] N_AMOSTRAS = 5'(1 << K_AMOSTRAS);
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GAP     = 2'd2,
        PUBLISH = 2'd3
    } estado_t;

    estado_t          state_q, state_d;
    logic [1:0]       canal_q, canal_d;
    logic [4:0]       conta_q, conta_d;       // samples taken on the current channel
    logic [7:0]       espera_q, espera_d;     // REQ cycles already spent on this sample
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             erro_rodada_q, erro_rodada_d;
    logic [3:0]       est_temp_q, est_temp_d; // staging, channels 0..2
    logic [3:0]       est_ph_q, est_ph_d;
    logic [3:0]       est_lum_q, est_lum_d;
    logic [3:0]       temp_q, temp_d;
    logic [3:0]       ph_q, ph_d;
    logic [3:0]       lum_q, lum_d;
    logic [3:0]       umi_q, umi_d;
    logic             erro_q, erro_d;
    logic             req_q, req_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;

    // Truncating average: drop the K low bits of the sum.
    logic [3:0] media;
    assign media = acc_q[K_AMOSTRAS+3:K_AMOSTRAS];

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            canal_q       <= 2'd0;
            conta_q       <= 5'd0;
            espera_q      <= 8'd0;
            acc_q         <= '0;
            erro_rodada_q <= 1'b0;
            est_temp_q    <= 4'd0;
            est_ph_q      <= 4'd0;
            est_lum_q     <= 4'd0;
            temp_q        <= 4'd0;
            ph_q          <= 4'd0;
            lum_q         <= 4'd0;
            umi_q         <= 4'd0;
            erro_q        <= 1'b0;
            req_q         <= 1'b0;
            pronto_q      <= 1'b0;
            ocupado_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            canal_q       <= canal_d;
            conta_q       <= conta_d;
            espera_q      <= espera_d;
            acc_q         <= acc_d;
            erro_rodada_q <= erro_rodada_d;
            est_temp_q    <= est_temp_d;
            est_ph_q      <= est_ph_d;
            est_lum_q     <= est_lum_d;
            temp_q        <= temp_d;
            ph_q          <= ph_d;
            lum_q         <= lum_d;
            umi_q         <= umi_d;
            erro_q        <= erro_d;
            req_q         <= req_d;
            pronto_q      <= pronto_d;
            ocupado_q     <= ocupado_d;
        end
    end

    // ---------------------------------------------------------------- next state / datapath
    always_comb begin
        state_d       = state_q;
        canal_d       = canal_q;
        conta_d       = conta_q;
        espera_d      = espera_q;
        acc_d         = acc_q;
        erro_rodada_d = erro_rodada_q;
        est_temp_d    = est_temp_q;
        est_ph_d      = est_ph_q;
        est_lum_d     = est_lum_q;
        temp_d        = temp_q;
        ph_d          = ph_q;
        lum_d         = lum_q;
        umi_d         = umi_q;
        erro_d        = erro_q;

        case (state_q)
            IDLE, PUBLISH: begin
                if (enable) begin
                    state_d       = REQ;
                    canal_d       = 2'd0;
                    conta_d       = 5'd0;
                    espera_d      = 8'd0;
                    acc_d         = '0;
                    erro_rodada_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            REQ: begin
                // Valid data wins even on the timeout edge.
                if (sensor_valido) begin
                    acc_d   = acc_q + ACC_W'(sensor_dado);
                    conta_d = conta_q + 5'd1;
                    state_d = GAP;
                end else if (espera_q == TIMEOUT_M1) begin
                    // A timed-out sample counts as a 0 reading.
                    erro_rodada_d = 1'b1;
                    conta_d       = conta_q + 5'd1;
                    state_d       = GAP;
                end else begin
                    espera_d = espera_q + 8'd1;
                end
            end

            GAP: begin
                espera_d = 8'd0;
                state_d  = REQ;
                if (conta_q == N_AMOSTRAS) begin
                    acc_d   = '0;
                    conta_d = 5'd0;
                    canal_d = canal_q + 2'd1;
                    case (canal_q)
                        2'd0: est_temp_d = media;
                        2'd1: est_ph_d   = media;
                        2'd2: est_lum_d  = media;
                        default: begin
                            // Last channel goes straight to the outputs
                            // together with the staged ones.
                            temp_d  = est_temp_q;
                            ph_d    = est_ph_q;
                            lum_d   = est_lum_q;
                            umi_d   = media;
                            erro_d  = erro_rodada_q;
                            state_d = PUBLISH;
                        end
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Registered from the next state so they line up with the state register.
    always_comb begin
        req_d     = (state_d == REQ);
        pronto_d  = (state_d == PUBLISH);
        ocupado_d = (state_d != IDLE);
    end

    assign sensor_req   = req_q;
    assign sensor_sel   = canal_q;
    assign temperatura  = temp_q;
    assign pH           = ph_q;
    assign luminosidade = lum_q;
    assign umidade      = umi_q;
    assign pronto       = pronto_q;
    assign erro         = erro_q;
    assign ocupado      = ocupado_q;
    assign estado_dbg   = state_q;

endmodule

// File: tb/tb_amostrador_sensores.sv
// -----------------------------------------------------------------------------
// Bench for amostrador_sensores (K_AMOSTRAS=2, TIMEOUT=15).
// A sensor model answers every request from a per-channel table of samples.
// Every round the stimulus pushes the hand-computed set {erro,T,pH,L,U} and the
// absolute cycle of its pronto strobe. The monitor pops and compares whenever
// pronto is seen, and checks that outputs hold between strobes.
// -----------------------------------------------------------------------------
module tb_amostrador_sensores;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] sensor_dado;
    logic       sensor_valido;
    logic       sensor_req;
    logic [1:0] sensor_sel;
    logic [3:0] temperatura, pH, luminosidade, umidade;
    logic       pronto, erro, ocupado;
    logic [1:0] estado_dbg;

    // ---------------------------------------------------------------- clock / reset
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    amostrador_sensores #(.K_AMOSTRAS(2), .TIMEOUT(15)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sensor_dado  (sensor_dado),
        .sensor_valido(sensor_valido),
        .sensor_req   (sensor_req),
        .sensor_sel   (sensor_sel),
        .temperatura  (temperatura),
        .pH           (pH),
        .luminosidade (luminosidade),
        .umidade      (umidade),
        .pronto       (pronto),
        .erro         (erro),
        .ocupado      (ocupado),
        .estado_dbg   (estado_dbg)
    );

    // ---------------------------------------------------------------- scoreboard state
    logic [16:0] exp_q[$];
    int          exp_lat_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] last_pub = '0;
    bit          mon_en = 0;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, got, want, cyc);
        end
    endtask

    // ---------------------------------------------------------------- sensor model
    logic [3:0] val_tab [4][4];
    int         idx [4];
    bit         silent [4];
    bit         noise = 0;

    always @(negedge clock) begin
        if (sensor_req === 1'b1) begin
            if (silent[sensor_sel]) begin
                sensor_valido = 1'b0;
                sensor_dado   = 4'd0;
            end else begin
                sensor_valido    = 1'b1;
                sensor_dado      = val_tab[sensor_sel][idx[sensor_sel]];
                idx[sensor_sel]  = (idx[sensor_sel] + 1) % 4;
            end
        end else if (noise) begin
            sensor_valido = 1'b1;
            sensor_dado   = 4'hF;
        end else begin
            sensor_valido = 1'b0;
            sensor_dado   = 4'd0;
        end
    end

    // ---------------------------------------------------------------- monitor
    logic [16:0] mon_got;
    logic [16:0] mon_exp;
    always @(negedge clock) begin
        if (mon_en) begin
            mon_got = {erro, temperatura, pH, luminosidade, umidade};
            if (pronto === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected pronto: got set %0h with nothing expected (cycle %0d)", mon_got, cyc);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    check("published set", mon_got, mon_exp);
                    last_pub = mon_exp;
                    check("pronto cycle", cyc, exp_lat_q.pop_front());
                end
            end else begin
                check("hold between strobes", mon_got, last_pub);
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic set_const(input logic [3:0] t, input logic [3:0] p,
                             input logic [3:0] l, input logic [3:0] u);
        for (int i = 0; i < 4; i++) begin
            val_tab[0][i] = t;
            val_tab[1][i] = p;
            val_tab[2][i] = l;
            val_tab[3][i] = u;
        end
        for (int c = 0; c < 4; c++) idx[c] = 0;
    endtask

    task automatic expect_round(input logic e, input logic [3:0] t, input logic [3:0] p,
                                input logic [3:0] l, input logic [3:0] u, input int at_cyc);
        exp_q.push_back({e, t, p, l, u});
        exp_lat_q.push_back(at_cyc);
    endtask

    task automatic wait_pronto(input int budget, input string nome);
        int n;
        n = 0;
        @(negedge clock);
        while (pronto !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        n_cmp++;
        if (pronto !== 1'b1) begin
            n_err++;
            $display("FAIL %s: pronto not seen within %0d cycles", nome, budget);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    bit          flag;
    int          t0;
    int          n;

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        sensor_valido = 1'b0;
        sensor_dado   = 4'd0;
        for (int c = 0; c < 4; c++) silent[c] = 0;
        set_const(4'd0, 4'd0, 4'd0, 4'd0);

        repeat (3) @(negedge clock);
        check("reset outputs",
              {pronto, erro, temperatura, pH, luminosidade, umidade, sensor_req, sensor_sel, ocupado},
              32'd0);
        check("reset state", estado_dbg, 2'd0);
        reset = 1'b0;

        // Idle with enable low: no request, nothing busy, outputs stay 0.
        flag = 0;
        repeat (50) begin
            @(negedge clock);
            if (sensor_req !== 1'b0 || ocupado !== 1'b0 || pronto !== 1'b0) flag = 1;
        end
        check("idle no request", flag, 0);
        check("idle outputs", {erro, temperatura, pH, luminosidade, umidade}, 0);
        last_pub = '0;
        mon_en   = 1;

        // Constant sensors, single enable pulse.
        set_const(4'd9, 4'd7, 4'd3, 4'd12);
        expect_round(1'b0, 4'd9, 4'd7, 4'd3, 4'd12, cyc + 33);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        check("first REQ", {ocupado, sensor_req, sensor_sel}, 4'b1100);
        wait_pronto(100, "constant round");
        @(negedge clock);
        check("idle after pulse", {ocupado, sensor_req}, 2'b00);

        // Truncating average, with stray valid while no request is open.
        val_tab[0][0] = 4'd15; val_tab[0][1] = 4'd15; val_tab[0][2] = 4'd15; val_tab[0][3] = 4'd14;
        val_tab[1][0] = 4'd1;  val_tab[1][1] = 4'd0;  val_tab[1][2] = 4'd0;  val_tab[1][3] = 4'd0;
        val_tab[2][0] = 4'd5;  val_tab[2][1] = 4'd6;  val_tab[2][2] = 4'd7;  val_tab[2][3] = 4'd8;
        val_tab[3][0] = 4'd0;  val_tab[3][1] = 4'd0;  val_tab[3][2] = 4'd0;  val_tab[3][3] = 4'd3;
        for (int c = 0; c < 4; c++) idx[c] = 0;
        noise = 1;
        expect_round(1'b0, 4'd14, 4'd0, 4'd6, 4'd0, cyc + 33);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        wait_pronto(100, "average round");
        @(negedge clock);
        noise = 0;

        // Channel 2 never answers: 4 timeouts of 15 cycles.
        set_const(4'd8, 4'd8, 4'd8, 4'd8);
        silent[2] = 1;
        expect_round(1'b1, 4'd8, 4'd8, 4'd0, 4'd8, cyc + 89);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        wait_pronto(200, "timeout round");
        @(negedge clock);
        silent[2] = 0;

        // Good round clears erro.
        set_const(4'd8, 4'd8, 4'd3, 4'd8);
        expect_round(1'b0, 4'd8, 4'd8, 4'd3, 4'd8, cyc + 33);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        wait_pronto(100, "recovery round");
        @(negedge clock);

        // Continuous mode, values change between rounds, enable drops mid-round.
        t0 = cyc;
        set_const(4'd1, 4'd2, 4'd3, 4'd4);
        expect_round(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, t0 + 33);
        enable = 1'b1;
        wait_pronto(100, "continuous 1");
        set_const(4'd5, 4'd6, 4'd7, 4'd8);
        expect_round(1'b0, 4'd5, 4'd6, 4'd7, 4'd8, t0 + 66);
        wait_pronto(100, "continuous 2");
        set_const(4'd10, 4'd11, 4'd12, 4'd13);
        expect_round(1'b0, 4'd10, 4'd11, 4'd12, 4'd13, t0 + 99);
        repeat (5) @(negedge clock);
        enable = 1'b0;
        wait_pronto(100, "continuous 3");
        @(negedge clock);
        check("idle after continuous", {ocupado, sensor_req}, 2'b00);

        // Reset while requesting channel 1: immediate clear, nothing published.
        set_const(4'd2, 4'd4, 4'd6, 4'd8);
        expect_round(1'b0, 4'd2, 4'd4, 4'd6, 4'd8, cyc + 33);
        enable = 1'b1;
        n = 0;
        while (!(sensor_req === 1'b1 && sensor_sel === 2'd1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("reached channel 1", {sensor_req, sensor_sel}, 3'b101);
        #2;
        reset = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_lat_q.pop_back());
        last_pub = '0;
        #1;
        check("mid-round reset outputs",
              {pronto, erro, temperatura, pH, luminosidade, umidade, sensor_req, sensor_sel, ocupado},
              32'd0);
        @(negedge clock);
        reset = 1'b0;
        set_const(4'd2, 4'd4, 4'd6, 4'd8);
        expect_round(1'b0, 4'd2, 4'd4, 4'd6, 4'd8, cyc + 33);
        @(negedge clock);
        enable = 1'b0;
        wait_pronto(100, "round after reset");
        repeat (3) @(negedge clock);
        check("idle at end", {ocupado, sensor_req}, 2'b00);
        check("expected queue drained", exp_q.size(), 0);
        mon_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/amostrador_sensores.md
# amostrador_sensores

Acquisition stage feeding the averaging/grading stage. Polls the four field sensors (temperatura, pH, luminosidade, umidade) over one shared, multiplexed 4-bit request/valid sensor bus. It takes 2^K_AMOSTRAS readings per channel and averages them by truncating shift. All four 4-bit grades are published together with a one-cycle `pronto` strobe, so downstream always sees a coherent set from a single round.

## Interface
- K_AMOSTRAS, default 2: log2 of samples per channel per round (legal 0..4).
- TIMEOUT, default 15: max REQ cycles waiting for `sensor_valido` before substituting a 0 sample (legal 1..255).

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- enable  in  1  start/continue sampling; sampled only in IDLE and PUBLISH.
- sensor_dado  in  4  reading from the selected sensor.
- sensor_valido  in  1  `sensor_dado` valid; honoured only while `sensor_req`=1.
- sensor_req  out  1  read request to the sensor bus.
- sensor_sel  out  2  channel select: 0 temperatura, 1 pH, 2 luminosidade, 3 umidade.
- temperatura, pH, luminosidade, umidade  out  4 each  published averaged grades.
- pronto  out  1  high for exactly one cycle when a new set is published.
- erro  out  1  at least one sample in the published round timed out.
- ocupado  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, REQ, GAP, PUBLISH.
  - **IDLE**: `sensor_req`=0. If `enable`=1, go to REQ. On entry to the round, clear channel=0, sample count, accumulator and the round error flag.
  - **REQ**: `sensor_req`=1, `sensor_sel`=channel.
    - On an edge with `sensor_valido`=1: accumulator += `sensor_dado`, go to GAP.
    - Else, after TIMEOUT consecutive REQ cycles: accumulator += 0, set round error flag, go to GAP.
    - Valid on the timeout edge: data wins, no error.
  - **GAP**: `sensor_req`=0 for one cycle, so every request is a fresh rising edge.
    - If the channel's sample count has not reached 2^K: go to REQ, same channel.
    - Else: store accumulator[K+3:K] in the staging slot for the channel, clear the accumulator, then channel+1 and go to REQ. After channel 3, instead load all four outputs plus `erro` from staging and go to PUBLISH.
  - **PUBLISH**: `pronto`=1. If `enable`=1, start a new round (clear as above) and go to REQ. Else go to IDLE.
- `enable` falling mid-round does not abort; the round completes and publishes.
- Accumulator is 4+K bits and cannot overflow. Average = floor(sum/2^K), range 0..15.
- Outputs hold their last published value between rounds. They change only on the edge entering PUBLISH.
- `sensor_valido` while `sensor_req`=0 is ignored.

## Timing
- Reset values: all grades 0, `pronto` 0, `erro` 0, `sensor_req` 0, `sensor_sel` 0, `ocupado` 0; state IDLE. Asserting reset mid-round aborts immediately; nothing partial is published.
- Each sample takes (REQ cycles) + 1 GAP cycle. Minimum 2 cycles when valid is present in the first REQ cycle.
- Round latency with immediate valid: 4·2^K·2 cycles plus 1 PUBLISH cycle. For K=2, `pronto` is high in the 33rd cycle after the edge at which IDLE samples `enable`=1.
- Continuous mode (`enable` held high): next `sensor_req` rises the cycle after `pronto`. Back-to-back `pronto` pulses are 33 cycles apart for K=2.
- A timed-out sample occupies TIMEOUT REQ cycles + 1 GAP cycle.
- `ocupado` is registered from state and is high from the first REQ cycle through PUBLISH inclusive.

## Test plan
- Reset then idle, `enable`=0 for 50 cycles -> all outputs 0, `sensor_req` never rises.
- K=2, sensor model returns constant values per channel T=9, pH=7, L=3, U=12 with immediate valid; pulse `enable` -> `pronto` once at cycle 33 with 9/7/3/12, `erro`=0, then IDLE.
- K=2, temperatura samples 15,15,15,14 -> published temperatura=14 (sum 59>>2). pH samples 1,0,0,0 -> 0.
- Sensor never answers on channel 2 (TIMEOUT=15), others constant 8 -> luminosidade=0, `erro`=1. Round latency = 12·2 + 4·16 + 1 = 89 cycles. Next round with good sensor -> `erro`=0.
- `enable` held high; change sensor values between rounds -> `pronto` every 33 cycles, outputs stable between strobes. Drop `enable` mid-round -> round still publishes, then IDLE.
- Assert reset while in REQ on channel 1 -> outputs 0 and `sensor_req`=0 immediately. After release with `enable`=1, a full fresh round publishes correct values.
